// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 widths, error codes and unpadder FSM states
package sha2_pkg;
  localparam int BLOCK_W = 512;
  localparam int LEN_W = 64;
  localparam int MSG_W = BLOCK_W - LEN_W;
  localparam int WORD_W = 32;
  localparam int N_WORDS = MSG_W / WORD_W;
  localparam int IDX_W = $clog2(BLOCK_W);
  localparam int CNT_W = $clog2(N_WORDS);
  typedef enum logic [1:0] {ERR_OK, ERR_LEN, ERR_MARKER, ERR_FILL} err_e;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ALIGN, S_DONE} state_e;
endpackage

// File: rtl/sha2_unpadder_if.sv
// sha2_unpadder_if: padded-block input and unpacked-result output handshakes
// master drives in_valid/in_block/out_ready; slave (the unpadder) drives the rest
interface sha2_unpadder_if;
  import sha2_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [BLOCK_W-1:0] in_block;
  logic out_valid;
  logic out_ready;
  logic [MSG_W-1:0] out_plaintext;
  logic [LEN_W-1:0] out_length;
  logic [1:0] out_error;
  modport master (
    output in_valid, in_block, out_ready,
    input in_ready, out_valid, out_plaintext, out_length, out_error
  );
  modport slave (
    input in_valid, in_block, out_ready,
    output in_ready, out_valid, out_plaintext, out_length, out_error
  );
endinterface

// File: rtl/sha2_pad_slice_check.sv
// sha2_pad_slice_check: flags marker/fill violations in one WORD_W slice of a padded block
// slice_i: slice bits, top_i: block index of slice_i[WORD_W-1], len_i: message length L
// marker_fail_o: marker bit 511-L inside slice and clear; fill_fail_o: a bit below the marker set
module sha2_pad_slice_check
  import sha2_pkg::*;
(
  input  logic [WORD_W-1:0] slice_i,
  input  logic [IDX_W-1:0]  top_i,
  input  logic [IDX_W-1:0]  len_i,
  output logic              marker_fail_o,
  output logic              fill_fail_o
);
  logic [IDX_W-1:0] mark, lo;
  assign mark = IDX_W'(BLOCK_W - 1) - len_i;
  assign lo = top_i - IDX_W'(WORD_W - 1);
  always_comb begin
    marker_fail_o = 1'b0;
    fill_fail_o = 1'b0;
    for (int i = 0; i < WORD_W; i++) begin
      marker_fail_o = marker_fail_o | ((lo + IDX_W'(i)) == mark && !slice_i[i]);
      fill_fail_o = fill_fail_o | ((lo + IDX_W'(i)) < mark && slice_i[i]);
    end
  end
endmodule

// File: rtl/sha2_unpadder.sv
// sha2_unpadder: checks a SHA-2 padded block slice by slice and returns plaintext, length, error
// clk/rst: clock and synchronous active-high reset
// bus: slave side of sha2_unpadder_if (block in, result out, valid/ready on both)
module sha2_unpadder
  import sha2_pkg::*;
(
  input logic clk,
  input logic rst,
  sha2_unpadder_if.slave bus
);
  state_e state_q;
  err_e error_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MSG_W-1:0] block_q, plaintext_q;
  logic [LEN_W-1:0] len_q;
  logic in_ready_q, out_valid_q;
  logic [IDX_W-1:0] base, shamt;
  logic [WORD_W-1:0] slice;
  logic marker_fail, fill_fail, len_bad;
  // slices walk from the message MSB downwards; base indexes block_q (block bit minus LEN_W)
  assign base = IDX_W'(MSG_W - WORD_W) - IDX_W'(WORD_W) * IDX_W'(cnt_q);
  assign slice = block_q[base +: WORD_W];
  // 448-L fits IDX_W bits; L=0 shifts everything out
  assign shamt = IDX_W'(MSG_W) - len_q[IDX_W-1:0];
  assign len_bad = bus.in_block[LEN_W-1:0] > LEN_W'(MSG_W - 1);
  sha2_pad_slice_check u_chk (
    .slice_i      (slice),
    .top_i        (base + IDX_W'(LEN_W + WORD_W - 1)),
    .len_i        (len_q[IDX_W-1:0]),
    .marker_fail_o(marker_fail),
    .fill_fail_o  (fill_fail)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      error_q <= ERR_OK;
      cnt_q <= '0;
      block_q <= '0;
      len_q <= '0;
      plaintext_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          block_q <= bus.in_block[BLOCK_W-1:LEN_W];
          len_q <= bus.in_block[LEN_W-1:0];
          cnt_q <= '0;
          in_ready_q <= 1'b0;
          if (len_bad) begin
            state_q <= S_DONE;
            error_q <= ERR_LEN;
            plaintext_q <= '0;
            out_valid_q <= 1'b1;
          end else state_q <= S_CHECK;
        end
        S_CHECK: if (marker_fail || fill_fail) begin
          state_q <= S_DONE;
          error_q <= marker_fail ? ERR_MARKER : ERR_FILL;
          plaintext_q <= '0;
          out_valid_q <= 1'b1;
        end else if (cnt_q == CNT_W'(N_WORDS - 1)) state_q <= S_ALIGN;
        else cnt_q <= cnt_q + 1'b1;
        S_ALIGN: begin
          state_q <= S_DONE;
          error_q <= ERR_OK;
          plaintext_q <= block_q >> shamt;
          out_valid_q <= 1'b1;
        end
        S_DONE: if (bus.out_ready) begin
          state_q <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_plaintext = plaintext_q;
  assign bus.out_length = len_q;
  assign bus.out_error = error_q;
endmodule
